axil_regbank: RTL and testbench

AXIL_REGBANK -- requirements
Module: axil_regbank

---
 rtl/axil_regbank_pkg.sv | 10 +
 rtl/axil_strb_merge.sv | 15 +
 rtl/axil_regbank.sv | 182 ++++++++++++++++++
 tb/tb_axil_regbank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regbank_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the register bank.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge: lanes with strb=1 take the new byte, others keep the old one.
module axil_strb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   i_old,
  input  logic [DW-1:0]   i_new,
  input  logic [DW/8-1:0] i_strb,
  output logic [DW-1:0]   o_merged
);

  for (genvar b = 0; b < DW/8; b++) begin : g_lane
    assign o_merged[b*8 +: 8] = i_strb[b] ? i_new[b*8 +: 8] : i_old[b*8 +: 8];
  end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite slave exposing a bank of C_NUM_REGS registers, with optional
// read-only registers whose read value comes from ro_in.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_NUM_REGS   = 16,
  parameter int                    C_ADDR_WIDTH = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]              AWADDR,
  input  logic [2:0]                           AWPROT,
  input  logic                                 AWVALID,
  output logic                                 AWREADY,
  input  logic [C_DATA_WIDTH-1:0]              WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]            WSTRB,
  input  logic                                 WVALID,
  output logic                                 WREADY,
  output logic [1:0]                           BRESP,
  output logic                                 BVALID,
  input  logic                                 BREADY,
  input  logic [C_ADDR_WIDTH-1:0]              ARADDR,
  input  logic [2:0]                           ARPROT,
  input  logic                                 ARVALID,
  output logic                                 ARREADY,
  output logic [C_DATA_WIDTH-1:0]              RDATA,
  output logic [1:0]                           RRESP,
  output logic                                 RVALID,
  input  logic                                 RREADY,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   regs_out,
  output logic [C_NUM_REGS-1:0]                wr_pulse,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   ro_in
);

  localparam int NB   = C_DATA_WIDTH/8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = C_ADDR_WIDTH - LSB;
  localparam int IW   = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  logic                                   r_init;
  wstate_e                                r_wstate, w_wstate_nxt;
  rstate_e                                r_rstate, w_rstate_nxt;
  logic                                   r_aw_vld, r_w_vld;
  logic [IDXW-1:0]                        r_aw_idx;
  logic [C_DATA_WIDTH-1:0]                r_wdata;
  logic [NB-1:0]                          r_wstrb;
  logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] r_regs;
  logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] w_ro;
  logic [C_NUM_REGS-1:0]                  r_wr_pulse;
  logic [1:0]                             r_bresp, r_rresp;
  logic [C_DATA_WIDTH-1:0]                r_rdata;

  logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_commit, w_wok, w_rin;
  logic [IDXW-1:0]         w_widx, w_ridx;
  logic [IW-1:0]           w_wsel, w_rsel;
  logic [C_DATA_WIDTH-1:0] w_wdata, w_merged;
  logic [NB-1:0]           w_wstrb;
  logic                    w_unused;

  assign w_unused = ^{AWPROT, ARPROT, AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

  // Readies stay low until the first edge after reset release.
  assign AWREADY = r_init && (r_wstate == W_IDLE) && !r_aw_vld;
  assign WREADY  = r_init && (r_wstate == W_IDLE) && !r_w_vld;
  assign ARREADY = r_init && (r_rstate == R_IDLE);
  assign BVALID  = (r_wstate == W_RESP);
  assign RVALID  = (r_rstate == R_DATA);
  assign BRESP   = r_bresp;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;
  assign regs_out = r_regs;
  assign wr_pulse = r_wr_pulse;
  assign w_ro     = ro_in;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_b_hs  = BVALID && BREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  // A channel that arrives in the commit cycle bypasses its latch.
  assign w_widx   = r_aw_vld ? r_aw_idx : AWADDR[C_ADDR_WIDTH-1:LSB];
  assign w_wdata  = r_w_vld ? r_wdata : WDATA;
  assign w_wstrb  = r_w_vld ? r_wstrb : WSTRB;
  assign w_wsel   = w_widx[IW-1:0];
  assign w_wok    = (32'(w_widx) < C_NUM_REGS) && !C_RO_MASK[w_wsel];
  assign w_commit = (r_wstate == W_IDLE) && (r_aw_vld || w_aw_hs) && (r_w_vld || w_w_hs);

  assign w_ridx = ARADDR[C_ADDR_WIDTH-1:LSB];
  assign w_rsel = w_ridx[IW-1:0];
  assign w_rin  = (32'(w_ridx) < C_NUM_REGS);

  axil_strb_merge #(.DW(C_DATA_WIDTH)) u_merge (
    .i_old    (r_regs[w_wsel]),
    .i_new    (w_wdata),
    .i_strb   (w_wstrb),
    .o_merged (w_merged)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_init   <= 1'b0;
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_init   <= 1'b1;
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP: if (BREADY)   w_wstate_nxt = W_IDLE;
      default:              w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA: if (RREADY)  w_rstate_nxt = R_IDLE;
      default:             w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_vld   <= 1'b0;
      r_w_vld    <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_regs     <= '0;
      r_wr_pulse <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_vld <= 1'b1;
        r_aw_idx <= AWADDR[C_ADDR_WIDTH-1:LSB];
      end
      if (w_w_hs) begin
        r_w_vld <= 1'b1;
        r_wdata <= WDATA;
        r_wstrb <= WSTRB;
      end
      if (w_commit) begin
        r_bresp <= w_wok ? RESP_OKAY : RESP_SLVERR;
        if (w_wok) begin
          r_regs[w_wsel]     <= w_merged;
          r_wr_pulse[w_wsel] <= 1'b1;
        end
      end
      if (w_b_hs) begin
        r_aw_vld <= 1'b0;
        r_w_vld  <= 1'b0;
      end
    end
  end

  // Sampling r_regs here gives the pre-write value on a same-cycle write.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      if (w_rin) begin
        r_rdata <= C_RO_MASK[w_rsel] ? w_ro[w_rsel] : r_regs[w_rsel];
        r_rresp <= RESP_OKAY;
      end else begin
        r_rdata <= '0;
        r_rresp <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Randomized + directed bench for axil_regbank; a plain-array model tracks
// expected register contents for a normal instance and one with reg 3 read-only.
module tb_axil_regbank;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVE = 2'b10;
  localparam logic [31:0] RO3 = 32'h5EED_0303;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic [7:0] AWADDR = '0, ARADDR = '0;
  logic [2:0] AWPROT = '0, ARPROT = '0;
  logic AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [31:0] WDATA = '0;
  logic [3:0] WSTRB = '0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  logic [31:0] RDATA;
  logic [NR*DW-1:0] regs_out, ro_in;
  logic [NR-1:0] wr_pulse;
  logic ro_awready, ro_wready, ro_bvalid, ro_arready, ro_rvalid;
  logic [1:0] ro_bresp, ro_rresp;
  logic [31:0] ro_rdata;
  logic [NR*DW-1:0] ro_regs_out;
  logic [NR-1:0] ro_wr_pulse;

  axil_regbank dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .ro_in(ro_in)
  );

  axil_regbank #(.C_RO_MASK(16'h0008)) dut_ro (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(ro_awready),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(ro_wready),
    .BRESP(ro_bresp), .BVALID(ro_bvalid), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ro_arready),
    .RDATA(ro_rdata), .RRESP(ro_rresp), .RVALID(ro_rvalid), .RREADY(RREADY),
    .regs_out(ro_regs_out), .wr_pulse(ro_wr_pulse), .ro_in(ro_in)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_regs [NR];
  logic [31:0] m_rro  [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_rro[i] = '0; end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_r%0d", tag, i), regs_out[i*32 +: 32], m_regs[i]);
      chk($sformatf("%s_ro_r%0d", tag, i), ro_regs_out[i*32 +: 32], m_rro[i]);
    end
  endtask

  // Called at a negedge; lead>0 presents W that many cycles before AW, lead<0 the reverse.
  // bdelay<0 leaves the response pending (no BREADY).
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bdelay,
                           output logic [1:0] resp, output logic [1:0] resp_ro, output int aw_to_b);
    int cyc = 0;
    int awc = 0;
    bit ad = 0, wd = 0;
    int idx = int'(addr) >> 2;
    bit ok = idx < NR;
    bit ok_ro = ok && (idx != 3);
    logic [NR-1:0] ep = '0, ep_ro = '0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(ad && wd) && cyc < 50) begin
      AWVALID = !ad && (cyc >= lead);
      WVALID  = !wd && (cyc >= -lead);
      #1;
      if (AWVALID && AWREADY) begin ad = 1; awc = cyc; end
      if (WVALID && WREADY) wd = 1;
      @(negedge ACLK); cyc++;
    end
    AWVALID = 0; WVALID = 0;
    chk("wr_handshake_timeout", {63'd0, ad && wd}, 64'd1);
    while (!BVALID && cyc < 100) begin @(negedge ACLK); cyc++; end
    chk("bvalid_timeout", {63'd0, BVALID}, 64'd1);
    aw_to_b = cyc - awc;
    if (ok) begin m_regs[idx] = mrg(m_regs[idx], data, strb); ep[idx] = 1'b1; end
    if (ok_ro) begin m_rro[idx] = mrg(m_rro[idx], data, strb); ep_ro[idx] = 1'b1; end
    chk("wr_pulse", {48'd0, wr_pulse}, {48'd0, ep});
    chk("ro_wr_pulse", {48'd0, ro_wr_pulse}, {48'd0, ep_ro});
    if (ok) begin
      chk("regs_out_now", {32'd0, regs_out[idx*32 +: 32]}, {32'd0, m_regs[idx]});
      chk("ro_regs_out_now", {32'd0, ro_regs_out[idx*32 +: 32]}, {32'd0, m_rro[idx]});
    end
    chk("bresp", {62'd0, BRESP}, ok ? 64'd0 : 64'd2);
    chk("ro_bresp", {62'd0, ro_bresp}, ok_ro ? 64'd0 : 64'd2);
    resp = BRESP; resp_ro = ro_bresp;
    if (bdelay < 0) return;
    for (int k = 0; k < bdelay; k++) begin
      @(negedge ACLK);
      chk("bvalid_hold", {63'd0, BVALID}, 64'd1);
      chk("bresp_hold", {62'd0, BRESP}, {62'd0, resp});
      chk("awready_low_resp", {63'd0, AWREADY}, 64'd0);
      chk("wr_pulse_one_cycle", {48'd0, wr_pulse}, 64'd0);
    end
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    chk("wr_pulse_clear", {48'd0, wr_pulse}, 64'd0);
    chk("bvalid_clear", {63'd0, BVALID}, 64'd0);
  endtask

  // Expected values are taken at call time, i.e. before any concurrent write lands.
  task automatic axi_read(input logic [7:0] addr, input int rdelay);
    int cyc = 0;
    bit done = 0;
    int idx = int'(addr) >> 2;
    logic [31:0] ed = (idx < NR) ? m_regs[idx] : 32'd0;
    logic [31:0] ed_ro = (idx == 3) ? RO3 : ((idx < NR) ? m_rro[idx] : 32'd0);
    logic [1:0] er = (idx < NR) ? OKAY : SLVE;
    ARADDR = addr; ARVALID = 1;
    while (!done && cyc < 50) begin
      #1;
      if (ARREADY) done = 1;
      @(negedge ACLK); cyc++;
    end
    ARVALID = 0;
    chk("rd_handshake_timeout", {63'd0, done}, 64'd1);
    chk("rvalid_latency", {63'd0, RVALID}, 64'd1);
    chk($sformatf("rdata_%0h", addr), {32'd0, RDATA}, {32'd0, ed});
    chk("rresp", {62'd0, RRESP}, {62'd0, er});
    chk($sformatf("ro_rdata_%0h", addr), {32'd0, ro_rdata}, {32'd0, ed_ro});
    chk("ro_rresp", {62'd0, ro_rresp}, {62'd0, er});
    for (int k = 0; k < rdelay; k++) begin
      @(negedge ACLK);
      chk("rdata_hold", {32'd0, RDATA}, {32'd0, ed});
      chk("rvalid_hold", {63'd0, RVALID}, 64'd1);
    end
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    chk("rvalid_clear", {63'd0, RVALID}, 64'd0);
  endtask

  initial begin
    logic [1:0] rs, rr;
    int t;
    for (int i = 0; i < NR; i++) ro_in[i*32 +: 32] = $urandom;
    ro_in[3*32 +: 32] = RO3;
    model_clear();
    repeat (3) @(negedge ACLK);
    chk("rst_awready", {63'd0, AWREADY}, 64'd0);
    chk("rst_wready", {63'd0, WREADY}, 64'd0);
    chk("rst_arready", {63'd0, ARREADY}, 64'd0);
    chk("rst_bvalid", {63'd0, BVALID}, 64'd0);
    chk("rst_rvalid", {63'd0, RVALID}, 64'd0);
    chk("rst_rdata", {32'd0, RDATA}, 64'd0);
    chk("rst_wr_pulse", {48'd0, wr_pulse}, 64'd0);
    check_regs("rst");
    ARESETN = 1;
    #1 chk("awready_before_edge", {63'd0, AWREADY}, 64'd0);
    @(negedge ACLK);
    chk("awready_after_edge", {63'd0, AWREADY}, 64'd1);
    chk("arready_after_edge", {63'd0, ARREADY}, 64'd1);

    // Basic write/readback
    for (int i = 0; i < 4; i++) axi_write(8'(i*4), 32'(i+1), 4'hF, 0, 0, rs, rr, t);
    for (int i = 0; i < 4; i++) axi_read(8'(i*4), i);
    for (int i = 0; i < 4; i++) chk("basic_lit", {32'd0, regs_out[i*32 +: 32]}, 64'(i+1));

    // W three cycles ahead of AW
    axi_write(8'h08, 32'hAABBCCDD, 4'hF, 3, 0, rs, rr, t);
    chk("w_first_b_latency", 64'(t), 64'd1);
    chk("w_first_reg2", {32'd0, regs_out[2*32 +: 32]}, 64'h0000_0000_AABB_CCDD);

    // Partial strobes
    axi_write(8'h04, 32'h11223344, 4'hF, 0, 0, rs, rr, t);
    axi_write(8'h05, 32'hFFFFFFFF, 4'b0101, -2, 1, rs, rr, t);
    chk("strb_reg1", {32'd0, regs_out[1*32 +: 32]}, 64'h0000_0000_11FF_33FF);

    // Out of range and read-only
    axi_write(8'h40, 32'hDEADBEEF, 4'hF, 0, 0, rs, rr, t);
    chk("oor_bresp", {62'd0, rs}, 64'd2);
    check_regs("oor");
    axi_read(8'h40, 0);
    axi_write(8'h0C, 32'h00000077, 4'hF, 1, 0, rs, rr, t);
    chk("ro_wr_slverr", {62'd0, rr}, 64'd2);
    axi_read(8'h0C, 0);

    // Long BREADY stall
    axi_write(8'h10, 32'h0BAD_F00D, 4'hF, 0, 10, rs, rr, t);

    // Read and write of the same register in the same cycle
    fork
      axi_write(8'h10, 32'h1234_5678, 4'hF, 0, 0, rs, rr, t);
      axi_read(8'h10, 0);
    join
    axi_read(8'h10, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(8'($urandom_range(0, 8'h4F)), $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)), rs, rr, t);
      else
        axi_read(8'($urandom_range(0, 8'h4F)), int'($urandom_range(0, 2)));
    end
    check_regs("rand");

    // Reset while a write response is pending
    axi_write(8'h14, 32'hFACE_CAFE, 4'hF, 0, -1, rs, rr, t);
    ARESETN = 0;
    #1;
    chk("midrst_bvalid", {63'd0, BVALID}, 64'd0);
    chk("midrst_awready", {63'd0, AWREADY}, 64'd0);
    model_clear();
    check_regs("midrst");
    @(negedge ACLK);
    ARESETN = 1;
    repeat (3) begin
      @(negedge ACLK);
      chk("postrst_no_b", {63'd0, BVALID}, 64'd0);
    end
    axi_write(8'h18, 32'h0000_AAAA, 4'hF, 0, 0, rs, rr, t);
    axi_read(8'h18, 0);
    axi_read(8'h14, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
